tftlcd_timing_ctrl: RTL

TFTLCD_TIMING_CTRL -- requirements
Module: tftlcd_timing_ctrl

---
 rtl/tftlcd_pkg.sv | 24 ++
 rtl/tftlcd_timing_ctrl_if.sv | 45 ++++
 rtl/tftlcd_seg_fsm.sv | 50 +++++
 rtl/tftlcd_timing_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/tftlcd_pkg.sv
// Shared types and default widths for the TFT-LCD timing controller.
package tftlcd_pkg;

  localparam int unsigned H_W_DEF = 11;
  localparam int unsigned V_W_DEF = 10;
  localparam int unsigned SEG_W   = 2;

  typedef enum logic [1:0] {
    H_ACT  = 2'd0,
    H_FP   = 2'd1,
    H_SYNC = 2'd2,
    H_BP   = 2'd3
  } h_state_t;

  // Segment codes match the sequencer index so a zero-extend maps them directly.
  typedef enum logic [2:0] {
    V_ACT  = 3'd0,
    V_FP   = 3'd1,
    V_SYNC = 3'd2,
    V_BP   = 3'd3,
    IDLE   = 3'd4
  } v_state_t;

endpackage

// File: rtl/tftlcd_timing_ctrl_if.sv
// Config, pixel-tick and video-timing signals between the register block and the timing controller.
interface tftlcd_timing_ctrl_if
  import tftlcd_pkg::*;
#(
  parameter int unsigned H_W = H_W_DEF,
  parameter int unsigned V_W = V_W_DEF
);

  logic           pix_ce;
  logic           en;
  logic [H_W-1:0] cfg_h_act;
  logic [H_W-1:0] cfg_h_fp;
  logic [H_W-1:0] cfg_h_sync;
  logic [H_W-1:0] cfg_h_bp;
  logic [V_W-1:0] cfg_v_act;
  logic [V_W-1:0] cfg_v_fp;
  logic [V_W-1:0] cfg_v_sync;
  logic [V_W-1:0] cfg_v_bp;
  logic           cfg_hs_pol;
  logic           cfg_vs_pol;
  logic           hsync;
  logic           vsync;
  logic           de;
  logic [H_W-1:0] pix_x;
  logic [V_W-1:0] pix_y;
  logic           busy;
  logic           frame_done;

  modport master (
    output pix_ce, en,
    output cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp,
    output cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp,
    output cfg_hs_pol, cfg_vs_pol,
    input  hsync, vsync, de, pix_x, pix_y, busy, frame_done
  );

  modport slave (
    input  pix_ce, en,
    input  cfg_h_act, cfg_h_fp, cfg_h_sync, cfg_h_bp,
    input  cfg_v_act, cfg_v_fp, cfg_v_sync, cfg_v_bp,
    input  cfg_hs_pol, cfg_vs_pol,
    output hsync, vsync, de, pix_x, pix_y, busy, frame_done
  );

endinterface

// File: rtl/tftlcd_seg_fsm.sv
// Generic 4-segment sequencer: holds each segment for its length in steps, 0 treated as 1.
module tftlcd_seg_fsm
  import tftlcd_pkg::*;
#(
  parameter int unsigned W = H_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [W-1:0]     len0,
  input  logic [W-1:0]     len1,
  input  logic [W-1:0]     len2,
  input  logic [W-1:0]     len3,
  output logic [SEG_W-1:0] seg,
  output logic [W-1:0]     cnt,
  output logic             wrap_c
);

  logic [W-1:0] cur_len;
  logic         last_c;

  always_comb begin
    cur_len = len0;
    case (seg)
      2'd1:    cur_len = len1;
      2'd2:    cur_len = len2;
      2'd3:    cur_len = len3;
      default: cur_len = len0;
    endcase
    last_c = (cur_len <= W'(1)) || (cnt >= cur_len - W'(1));
  end

  assign wrap_c = step && (seg == SEG_W'(3)) && last_c;

  always_ff @(posedge clk) begin
    if (rst || load) begin
      seg <= '0;
      cnt <= '0;
    end else if (step) begin
      if (last_c) begin
        cnt <= '0;
        seg <= seg + SEG_W'(1);
      end else begin
        cnt <= cnt + W'(1);
      end
    end
  end

endmodule

// File: rtl/tftlcd_timing_ctrl.sv
// TFT-LCD sync/DE timing generator: shadowed config, pix_ce-gated h/v sequencers, registered outputs.
module tftlcd_timing_ctrl
  import tftlcd_pkg::*;
#(
  parameter int unsigned H_W = H_W_DEF,
  parameter int unsigned V_W = V_W_DEF
) (
  input logic                 ACLK,
  input logic                 ARESET,
  tftlcd_timing_ctrl_if.slave bus
);

  logic           run;
  logic [H_W-1:0] sh_h_act, sh_h_fp, sh_h_sync, sh_h_bp;
  logic [V_W-1:0] sh_v_act, sh_v_fp, sh_v_sync, sh_v_bp;
  logic           sh_hs_pol, sh_vs_pol;

  logic [SEG_W-1:0] h_seg, v_seg;
  logic [H_W-1:0]   h_cnt;
  logic [V_W-1:0]   v_cnt;
  logic             start_c, h_step_c, h_wrap_c, frame_end_c;
  h_state_t         h_state_c;
  v_state_t         v_state_c;
  logic             hs_pol_c, vs_pol_c, de_c;

  assign start_c  = bus.pix_ce && !run && bus.en;
  assign h_step_c = bus.pix_ce && run;

  tftlcd_seg_fsm #(.W(H_W)) u_h_seq (
    .clk    (ACLK),
    .rst    (ARESET),
    .load   (!run),
    .step   (h_step_c),
    .len0   (sh_h_act),
    .len1   (sh_h_fp),
    .len2   (sh_h_sync),
    .len3   (sh_h_bp),
    .seg    (h_seg),
    .cnt    (h_cnt),
    .wrap_c (h_wrap_c)
  );

  // Vertical axis advances once per line, on the tick that leaves H_BP.
  tftlcd_seg_fsm #(.W(V_W)) u_v_seq (
    .clk    (ACLK),
    .rst    (ARESET),
    .load   (!run),
    .step   (h_wrap_c),
    .len0   (sh_v_act),
    .len1   (sh_v_fp),
    .len2   (sh_v_sync),
    .len3   (sh_v_bp),
    .seg    (v_seg),
    .cnt    (v_cnt),
    .wrap_c (frame_end_c)
  );

  // Shadows load on leaving IDLE and at every frame end; run follows en at those points.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      run       <= 1'b0;
      sh_h_act  <= '0;
      sh_h_fp   <= '0;
      sh_h_sync <= '0;
      sh_h_bp   <= '0;
      sh_v_act  <= '0;
      sh_v_fp   <= '0;
      sh_v_sync <= '0;
      sh_v_bp   <= '0;
      sh_hs_pol <= 1'b0;
      sh_vs_pol <= 1'b0;
    end else if (start_c || frame_end_c) begin
      run       <= bus.en;
      sh_h_act  <= bus.cfg_h_act;
      sh_h_fp   <= bus.cfg_h_fp;
      sh_h_sync <= bus.cfg_h_sync;
      sh_h_bp   <= bus.cfg_h_bp;
      sh_v_act  <= bus.cfg_v_act;
      sh_v_fp   <= bus.cfg_v_fp;
      sh_v_sync <= bus.cfg_v_sync;
      sh_v_bp   <= bus.cfg_v_bp;
      sh_hs_pol <= bus.cfg_hs_pol;
      sh_vs_pol <= bus.cfg_vs_pol;
    end
  end

  always_comb begin
    h_state_c = h_state_t'(h_seg);
    v_state_c = run ? v_state_t'(3'(v_seg)) : IDLE;
    hs_pol_c  = run ? sh_hs_pol : bus.cfg_hs_pol;
    vs_pol_c  = run ? sh_vs_pol : bus.cfg_vs_pol;
    de_c      = (h_state_c == H_ACT) && (v_state_c == V_ACT);
  end

  // Idle polarity tracks live config; in-frame polarity comes from the shadow.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      bus.hsync      <= ~bus.cfg_hs_pol;
      bus.vsync      <= ~bus.cfg_vs_pol;
      bus.de         <= 1'b0;
      bus.pix_x      <= '0;
      bus.pix_y      <= '0;
      bus.busy       <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.hsync      <= (run && h_state_c == H_SYNC) ? hs_pol_c : ~hs_pol_c;
      bus.vsync      <= (v_state_c == V_SYNC) ? vs_pol_c : ~vs_pol_c;
      bus.de         <= de_c;
      bus.busy       <= run;
      bus.frame_done <= frame_end_c;
      if (de_c) begin
        bus.pix_x <= h_cnt;
        bus.pix_y <= v_cnt;
      end
    end
  end

endmodule
